// File: rtl/audio_pkg.sv
// Shared types and widths for the audio playback controller.
// AUDIO_LOOP_EN (optional define) selects endless clip looping in audio_playback_ctrl.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ADDR_W   = 20;
    localparam int unsigned FRAME_W  = 32;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPrefetch = 2'd1,
        StPlay     = 2'd2,
        StDone     = 2'd3
    } state_e;

endpackage

// File: rtl/audio_i2s_serializer.sv
// I2S serializer: synchronizes the codec-mastered BCLK/LRCK, reports frame starts
// (synchronized LRCK falling edge) and shifts out left then right sample MSB-first.
module audio_i2s_serializer
    import audio_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               aud_bclk,
    input  logic               aud_daclrck,
    input  logic               enable,
    input  logic [FRAME_W-1:0] frame_data,
    output logic               frame_start,
    output logic               aud_dacdat
);

    localparam logic [4:0] BIT_LAST = 5'(SAMPLE_W);

    // [0] and [1] form the 2-FF synchronizer, [2] holds the previous synchronized value
    logic [2:0] bclk_sync;
    logic [2:0] lrck_sync;

    logic bclk_fall;
    logic lrck_fall;
    logic lrck_rise;

    logic [SAMPLE_W-1:0] right_q;
    logic [SAMPLE_W-1:0] shift_q;
    logic [4:0]          bit_cnt_q;
    logic                dacdat_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], aud_bclk};
            lrck_sync <= {lrck_sync[1:0], aud_daclrck};
        end
    end

    assign bclk_fall   = bclk_sync[2] & ~bclk_sync[1];
    assign lrck_fall   = lrck_sync[2] & ~lrck_sync[1];
    assign lrck_rise   = ~lrck_sync[2] & lrck_sync[1];
    assign frame_start = lrck_fall;

    // An LRCK edge only loads the channel; the MSB goes out on the following BCLK fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            right_q   <= '0;
            shift_q   <= '0;
            bit_cnt_q <= BIT_LAST;
            dacdat_q  <= 1'b0;
        end else if (!enable) begin
            right_q   <= '0;
            shift_q   <= '0;
            bit_cnt_q <= BIT_LAST;
            dacdat_q  <= 1'b0;
        end else if (lrck_fall) begin
            shift_q   <= frame_data[FRAME_W-1:SAMPLE_W];
            right_q   <= frame_data[SAMPLE_W-1:0];
            bit_cnt_q <= '0;
            dacdat_q  <= 1'b0;
        end else if (lrck_rise) begin
            shift_q   <= right_q;
            bit_cnt_q <= '0;
            dacdat_q  <= 1'b0;
        end else if (bclk_fall) begin
            if (bit_cnt_q < BIT_LAST) begin
                dacdat_q  <= shift_q[SAMPLE_W-1];
                shift_q   <= {shift_q[SAMPLE_W-2:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 5'd1;
            end else begin
                dacdat_q <= 1'b0;
            end
        end
    end

    assign aud_dacdat = dacdat_q;

endmodule

// File: rtl/audio_playback_ctrl.sv
// Audio clip playback: fetches stereo frames from memory into a one-entry buffer and
// feeds the I2S serializer once per LRCK period. Define AUDIO_LOOP_EN to loop the clip.
module audio_playback_ctrl
    import audio_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [31:0]        length,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [FRAME_W-1:0] mem_rdata,
    input  logic               aud_bclk,
    input  logic               aud_daclrck,
    output logic               aud_dacdat,
    output logic [31:0]        position,
    output logic               playing,
    output logic               done,
    output logic               underrun
);

    state_e             state_q,    state_d;
    logic [31:0]        length_q,   length_d;
    logic [31:0]        position_q, position_d;
    logic               mem_req_q,  mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [FRAME_W-1:0] buf_q,      buf_d;
    logic               buf_full_q, buf_full_d;
    logic               underrun_q, underrun_d;

    logic               frame_start;
    logic               ser_enable;
    logic [FRAME_W-1:0] ser_frame;
    logic               fetch_done;
    logic [31:0]        next_pos;
    logic               fetch_more;
    logic [ADDR_W-1:0]  fetch_addr;

    assign fetch_done = mem_req_q & mem_ack;

    // Position and address of the fetch that follows a consumed frame.
    always_comb begin
`ifdef AUDIO_LOOP_EN
        next_pos   = (position_q == length_q) ? 32'd1 : position_q + 32'd1;
        fetch_more = 1'b1;
        fetch_addr = (next_pos == length_q) ? '0 : next_pos[ADDR_W-1:0];
`else
        next_pos   = position_q + 32'd1;
        fetch_more = (next_pos < length_q);
        fetch_addr = next_pos[ADDR_W-1:0];
`endif
    end

    always_comb begin
        state_d    = state_q;
        length_d   = length_q;
        position_d = position_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        underrun_d = underrun_q;

        if (fetch_done) begin
            buf_d      = mem_rdata;
            buf_full_d = 1'b1;
            mem_req_d  = 1'b0;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    length_d   = length;
                    position_d = '0;
                    underrun_d = 1'b0;
                    buf_full_d = 1'b0;
                    if (length == 32'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StPrefetch;
                        mem_req_d  = 1'b1;
                        mem_addr_d = '0;
                    end
                end
            end
            StPrefetch: begin
                if (fetch_done) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (frame_start) begin
                    if (buf_full_q) begin
                        buf_full_d = 1'b0;
                        position_d = next_pos;
                        if (fetch_more) begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = fetch_addr;
                        end
`ifdef AUDIO_LOOP_EN
                    end else begin
                        underrun_d = 1'b1;
                    end
`else
                    end else if (position_q == length_q) begin
                        state_d = StDone;
                    end else begin
                        underrun_d = 1'b1;
                    end
`endif
                end
            end
        endcase

        if (stop) begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            length_q   <= '0;
            position_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            position_q <= position_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            underrun_q <= underrun_d;
        end
    end

    // An empty buffer at frame start plays a silent frame.
    assign ser_enable = (state_q == StPlay) && !stop;
    assign ser_frame  = buf_full_q ? buf_q : '0;

    audio_i2s_serializer u_serializer (
        .clk         (clk),
        .reset_n     (reset_n),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .enable      (ser_enable),
        .frame_data  (ser_frame),
        .frame_start (frame_start),
        .aud_dacdat  (aud_dacdat)
    );

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign position = position_q;
    assign playing  = (state_q == StPrefetch) || (state_q == StPlay);
    assign done     = (state_q == StDone);
    assign underrun = underrun_q;

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Directed bench for audio_playback_ctrl: codec BCLK/LRCK model captures I2S words,
// a memory model answers fetches with one-cycle latency.
`timescale 1ns/1ps
module tb_audio_playback_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] length = '0;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        aud_bclk = 1'b1;
    logic        aud_daclrck = 1'b1;
    logic        aud_dacdat;
    logic [31:0] position;
    logic        playing;
    logic        done;
    logic        underrun;

    int n_cmp = 0;
    int n_bad = 0;

    audio_playback_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .length      (length),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat),
        .position    (position),
        .playing     (playing),
        .done        (done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: one-cycle ack latency, optional stall of the address-1 fetch
    logic [31:0] mem [16];
    logic        stall1 = 1'b0;
    logic [19:0] addr_log [$];

    always @(posedge clk) begin
        if (mem_req && !mem_ack && !(stall1 && mem_addr == 20'd1)) begin
            mem_ack   <= 1'b1;
            mem_rdata <= mem[mem_addr[3:0]];
            addr_log.push_back(mem_addr);
        end else begin
            mem_ack <= 1'b0;
        end
    end

    // Codec model: 18 BCLKs (80 ns) per channel, data sampled on BCLK rising edges
    localparam int HalfBclk = 18;
    logic [15:0] cap_l [$];
    logic [15:0] cap_r [$];
    logic [31:0] cap_pos [$];
    int frame_cnt = 0;

    task automatic codec_half(input logic lr, output logic [15:0] word);
        word = '0;
        for (int i = 0; i < HalfBclk; i++) begin
            aud_bclk = 1'b0;
            if (i == 0) aud_daclrck = lr;
            #40;
            aud_bclk = 1'b1;
            if (i >= 1 && i <= 16) word = {word[14:0], aud_dacdat};
            #40;
        end
    endtask

    initial begin
        logic [15:0] l;
        logic [15:0] r;
        #3;
        forever begin
            codec_half(1'b0, l);
            cap_pos.push_back(position);
            codec_half(1'b1, r);
            cap_l.push_back(l);
            cap_r.push_back(r);
            frame_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start(input logic [31:0] len);
        @(negedge clk);
        length = len;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Returns index of the first frame the DUT will play after a start issued now
    task automatic sync_frame(output int f);
        int c;
        c = frame_cnt;
        wait (frame_cnt != c);
        repeat (20) @(posedge clk);
        f = frame_cnt + 1;
    endtask

    task automatic check_frame(input string tag, input int k, input logic [15:0] l,
                               input logic [15:0] r, input logic [31:0] pos);
        check({tag, "_left"}, cap_l[k], l);
        check({tag, "_right"}, cap_r[k], r);
        check({tag, "_pos"}, cap_pos[k], pos);
    endtask

    initial begin
        int f;
        mem[0] = 32'hAAAA5555;
        mem[1] = 32'h12340000;
        mem[2] = 32'hFFFF0001;
        for (int i = 3; i < 16; i++) mem[i] = 32'h0F0F0F0F;

        #1 reset_n = 1'b0;
        #20;
        check("rst_position", position, 32'd0);
        check("rst_playing", playing, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_dacdat", aud_dacdat, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

`ifdef AUDIO_LOOP_EN
        addr_log.delete();
        sync_frame(f);
        pulse_start(32'd2);
        wait (frame_cnt > f + 3);
        check("loop_pos0", cap_pos[f], 32'd1);
        check("loop_pos1", cap_pos[f + 1], 32'd2);
        check("loop_pos2", cap_pos[f + 2], 32'd1);
        check("loop_pos3", cap_pos[f + 3], 32'd2);
        check("loop_left2", cap_l[f + 2], 16'hAAAA);
        for (int i = 0; i < 5; i++) check($sformatf("loop_addr%0d", i), addr_log[i], i % 2);
        check("loop_done", done, 1'b0);
        check("loop_playing", playing, 1'b1);
        pulse_stop();
`else
        // Three-frame clip, bit-exact output then end of clip
        sync_frame(f);
        pulse_start(32'd3);
        check("t1_playing", playing, 1'b1);
        check("t1_mem_req", mem_req, 1'b1);
        check("t1_mem_addr", mem_addr, 20'd0);
        wait (frame_cnt == f + 1);
        repeat (50) @(posedge clk);
        pulse_start(32'd0);
        check("t1_start_ignored_playing", playing, 1'b1);
        check("t1_start_ignored_pos", position, 32'd2);
        wait (frame_cnt > f + 3);
        check_frame("t1_f1", f, 16'hAAAA, 16'h5555, 32'd1);
        check_frame("t1_f2", f + 1, 16'h1234, 16'h0000, 32'd2);
        check_frame("t1_f3", f + 2, 16'hFFFF, 16'h0001, 32'd3);
        check_frame("t1_f4", f + 3, 16'h0000, 16'h0000, 32'd3);
        check("t1_done", done, 1'b1);
        check("t1_playing_end", playing, 1'b0);
        check("t1_underrun", underrun, 1'b0);

        // Late fetch of frame 2 -> silent frame, sticky underrun, position holds
        stall1 = 1'b1;
        sync_frame(f);
        pulse_start(32'd3);
        wait (frame_cnt == f + 1);
        repeat (100) @(posedge clk);
        check("t2_underrun", underrun, 1'b1);
        check("t2_pos_hold", position, 32'd1);
        stall1 = 1'b0;
        wait (frame_cnt > f + 3);
        repeat (10) @(posedge clk);
        check_frame("t2_f1", f, 16'hAAAA, 16'h5555, 32'd1);
        check_frame("t2_f2", f + 1, 16'h0000, 16'h0000, 32'd1);
        check_frame("t2_f3", f + 2, 16'h1234, 16'h0000, 32'd2);
        check_frame("t2_f4", f + 3, 16'hFFFF, 16'h0001, 32'd3);
        check("t2_done", done, 1'b1);
        check("t2_underrun_sticky", underrun, 1'b1);
`endif

        // Stop during frame 2 of a 10-frame clip
        for (int i = 0; i < 16; i++) mem[i] = 32'hFFFFFFFF;
        sync_frame(f);
        pulse_start(32'd10);
        check("t3_underrun_cleared", underrun, 1'b0);
        wait (frame_cnt == f + 1);
        repeat (50) @(posedge clk);
        check("t3_dacdat_live", aud_dacdat, 1'b1);
        pulse_stop();
        check("t3_playing", playing, 1'b0);
        check("t3_done", done, 1'b0);
        check("t3_mem_req", mem_req, 1'b0);
        check("t3_dacdat", aud_dacdat, 1'b0);
        check("t3_position", position, 32'd2);
        repeat (20) @(posedge clk);
        pulse_start(32'd10);
        check("t3_restart_pos", position, 32'd0);
        check("t3_restart_req", mem_req, 1'b1);
        check("t3_restart_addr", mem_addr, 20'd0);
        pulse_stop();

        // Zero-length clip, then simultaneous start and stop
        pulse_start(32'd0);
        check("t4_done", done, 1'b1);
        check("t4_mem_req", mem_req, 1'b0);
        check("t4_playing", playing, 1'b0);
        pulse_stop();
        check("t4_idle_done", done, 1'b0);
        @(negedge clk);
        length = 32'd5;
        start  = 1'b1;
        stop   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("t4_both_playing", playing, 1'b0);
        check("t4_both_done", done, 1'b0);
        repeat (3) @(posedge clk);
        check("t4_both_req", mem_req, 1'b0);

        // Asynchronous reset mid-PLAY with a fetch outstanding
        mem[0] = 32'hAAAA5555;
        stall1 = 1'b1;
        sync_frame(f);
        pulse_start(32'd3);
        wait (frame_cnt == f);
        repeat (50) @(posedge clk);
        check("t5_pre_req", mem_req, 1'b1);
        check("t5_pre_pos", position, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_mem_req", mem_req, 1'b0);
        check("t5_mem_addr", mem_addr, 20'd0);
        check("t5_position", position, 32'd0);
        check("t5_playing", playing, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_dacdat", aud_dacdat, 1'b0);
        check("t5_underrun", underrun, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        stall1  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
